// File: rtl/sram_burst_ctrl.sv
// Burst sequencer that turns one address/length/direction command into a run of single-port SRAM cycles.
// Latency: first SRAM access the cycle after command accept; read data returns one cycle after each rden.
// Backpressure: commands only in IDLE (cmd_ready); write beats stall on wdata_valid; read beats cannot be stalled.
//
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake; cmd_write, cmd_addr, cmd_len (beats minus one)
//   wdata_valid/wdata_ready, wdata     write beat stream
//   rdata_valid, rdata, rdata_last     read beat stream (no backpressure)
//   busy                               burst in flight or final read beat still returning
//   sram_wren/rden/addr/wr_data/rd_data  connection to the single-port sram block
//
// Optional feature: define SRAM_BURST_WRAP_EN for wrapping bursts. Only the low LEN_WIDTH address
// bits then count, so the burst stays inside its 2**LEN_WIDTH-word aligned block.

package sram_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
endpackage

module sram_burst_ctrl #(
  parameter int ADDR_WIDTH = sram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  busy,
  output logic                  sram_wren,
  output logic                  sram_rden,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  input  logic [DATA_WIDTH-1:0] sram_rd_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_inc;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    rvld_q;
  logic                    rlast_q;

  // Address of the next beat.
`ifdef SRAM_BURST_WRAP_EN
  // Upper bits hold the block captured from cmd_addr; low bits roll over inside it.
  always_comb begin
    addr_inc                = addr_q;
    addr_inc[LEN_WIDTH-1:0] = addr_q[LEN_WIDTH-1:0] + LEN_ONE;
  end
`else
  // Plain increment; the top address rolls over to 0.
  assign addr_inc = addr_q + ADDR_ONE;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rvld_q  <= 1'b0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      // The sram read port is registered, so read beats come back one cycle after rden.
      rvld_q  <= sram_rden;
      rlast_q <= (state_q == READ) && (cnt_q == '0);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    cmd_ready    = 1'b0;
    wdata_ready  = 1'b0;
    sram_wren    = 1'b0;
    sram_rden    = 1'b0;
    sram_wr_data = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WRITE : READ;
        end
      end

      WRITE: begin
        wdata_ready  = 1'b1;
        sram_wr_data = wdata;
        sram_wren    = wdata_valid;
        if (wdata_valid) begin
          addr_d = addr_inc;
          cnt_d  = cnt_q - LEN_ONE;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end
        end
      end

      READ: begin
        sram_rden = 1'b1;
        addr_d    = addr_inc;
        cnt_d     = cnt_q - LEN_ONE;
        if (cnt_q == '0) begin
          state_d = DRAIN;
        end
      end

      // Spare cycle while the final read beat comes back; no SRAM access.
      DRAIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sram_addr   = addr_q;
  assign rdata       = sram_rd_data;
  assign rdata_valid = rvld_q;
  assign rdata_last  = rlast_q;
  assign busy        = (state_q != IDLE) || rvld_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Testbench for sram_burst_ctrl: drives burst commands against a behavioural registered-read SRAM.
// Expected SRAM accesses and read beats are queued as commands are issued, then checked as they appear.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.

module tb_sram_burst_ctrl;

  localparam int AW = sram_pkg::ADDR_WIDTH;
  localparam int DW = sram_pkg::DATA_WIDTH;
  localparam int LW = 4;
`ifdef SRAM_BURST_WRAP_EN
  localparam int TOP = 32'h1E;
`else
  localparam int TOP = (1 << AW) - 2;
`endif

  logic          clk;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          rdata_last;
  logic          busy;
  logic          sram_wren;
  logic          sram_rden;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wr_data;
  logic [DW-1:0] sram_rd_data;

  sram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wdata_valid  (wdata_valid),
    .wdata_ready  (wdata_ready),
    .wdata        (wdata),
    .rdata_valid  (rdata_valid),
    .rdata        (rdata),
    .rdata_last   (rdata_last),
    .busy         (busy),
    .sram_wren    (sram_wren),
    .sram_rden    (sram_rden),
    .sram_addr    (sram_addr),
    .sram_wr_data (sram_wr_data),
    .sram_rd_data (sram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM with registered read; wren wins over rden.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sram_rd_data <= '0;
    end else if (sram_wren) begin
      mem[sram_addr] <= sram_wr_data;
    end else if (sram_rden) begin
      sram_rd_data <= mem[sram_addr];
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_wren = 0;
  int n_rden = 0;
  int n_rvld = 0;

  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];
  logic [31:0] rq_addr [$];
  logic [31:0] dq_data [$];
  logic [31:0] dq_last [$];

  bit prev_rden = 1'b0;
  bit prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nxt(input int a);
`ifdef SRAM_BURST_WRAP_EN
    int m = (1 << LW) - 1;
    return (a & ~m) | ((a + 1) & m);
`else
    return (a + 1) % (1 << AW);
`endif
  endfunction

  function automatic logic [DW-1:0] dat(input int base, input int i);
    return DW'((base << 8) | i);
  endfunction

  // Monitor: every SRAM access and read beat must match the head of its queue.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_rden = 1'b0;
      prev_last = 1'b0;
    end else begin
      chk("wren_rden_excl", {31'b0, sram_wren & sram_rden}, 0);
      if (prev_last) chk("busy_after_last", {31'b0, busy}, 0);
      if (sram_wren) begin
        n_wren++;
        if (wq_addr.size() == 0) chk("unexpected_wren", wq_addr.size(), 1);
        else begin
          chk("wr_addr", sram_addr, wq_addr.pop_front());
          chk("wr_data", sram_wr_data, wq_data.pop_front());
        end
      end
      if (sram_rden) begin
        n_rden++;
        if (rq_addr.size() == 0) chk("unexpected_rden", rq_addr.size(), 1);
        else chk("rd_addr", sram_addr, rq_addr.pop_front());
      end
      if (rdata_valid) begin
        n_rvld++;
        chk("rvld_after_rden", {31'b0, prev_rden}, 1);
        if (dq_data.size() == 0) chk("unexpected_rvld", dq_data.size(), 1);
        else begin
          chk("rdata", rdata, dq_data.pop_front());
          chk("rdata_last", {31'b0, rdata_last}, dq_last.pop_front());
        end
      end else begin
        chk("rlast_without_valid", {31'b0, rdata_last}, 0);
      end
      prev_rden = sram_rden;
      prev_last = rdata_valid & rdata_last;
    end
  end

  task automatic issue_cmd(input bit wr, input int addr, input int len);
    for (int i = 0; i < 50 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!cmd_ready) chk("cmd_ready_wait", {31'b0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
  endtask

  // pat_n == 0: wdata_valid always high; otherwise bit c of pat gives wdata_valid in cycle c.
  task automatic wr_burst(input int addr, input int len, input int base, input int pat, input int pat_n);
    int a;
    int beat;
    int cyc;
    int w0;
    bit v;
    w0 = n_wren;
    issue_cmd(1'b1, addr, len);
    a = addr;
    for (int i = 0; i <= len; i++) begin
      wq_addr.push_back(a);
      wq_data.push_back(dat(base, i));
      ref_mem[a] = dat(base, i);
      a = nxt(a);
    end
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 200) begin
      v = (pat_n == 0 || cyc >= pat_n) ? 1'b1 : pat[cyc];
      wdata_valid = v;
      wdata       = dat(base, beat);
      @(posedge clk); #1;
      if (v) beat++;
      cyc++;
    end
    wdata_valid = 1'b0;
    wdata       = '0;
    chk("wr_cmd_ready_after_last", {31'b0, cmd_ready}, 1);
    chk("wr_beat_count", n_wren - w0, len + 1);
  endtask

  task automatic rd_burst(input int addr, input int len);
    int a;
    int r0;
    int v0;
    r0 = n_rden;
    v0 = n_rvld;
    issue_cmd(1'b0, addr, len);
    a = addr;
    for (int i = 0; i <= len; i++) begin
      rq_addr.push_back(a);
      dq_data.push_back(ref_mem[a]);
      dq_last.push_back((i == len) ? 1 : 0);
      a = nxt(a);
    end
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    if (busy) chk("rd_busy_timeout", {31'b0, busy}, 0);
    chk("rd_rden_count", n_rden - r0, len + 1);
    chk("rd_rvld_count", n_rvld - v0, len + 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},   {31'b0, cmd_ready}, 1);
    chk({tag, "_wdata_ready"}, {31'b0, wdata_ready}, 0);
    chk({tag, "_rdata_valid"}, {31'b0, rdata_valid}, 0);
    chk({tag, "_rdata_last"},  {31'b0, rdata_last}, 0);
    chk({tag, "_busy"},        {31'b0, busy}, 0);
    chk({tag, "_sram_wren"},   {31'b0, sram_wren}, 0);
    chk({tag, "_sram_rden"},   {31'b0, sram_rden}, 0);
    chk({tag, "_sram_addr"},   sram_addr, 0);
    chk({tag, "_sram_wr_data"}, sram_wr_data, 0);
    chk({tag, "_rdata"},       rdata, 0);
  endtask

  initial begin
    rstn        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Linear write then read-back of four beats.
    wr_burst(32'h04, 3, 32'hA0, 0, 0);
    rd_burst(32'h04, 3);

    // Stalled write: valid pattern 1,0,0,1,1 carries three beats.
    wr_burst(32'h20, 2, 32'hB0, 32'b11001, 5);
    rd_burst(32'h20, 2);

    // Burst across the top of the address space (or the wrap block).
    wr_burst(TOP, 3, 32'hC0, 0, 0);
    rd_burst(TOP, 3);

    // Single-beat write and read.
    wr_burst(32'h09, 0, 32'h90, 0, 0);
    rd_burst(32'h09, 0);

    // Reset two beats into an eight-beat read.
    wr_burst(32'h40, 7, 32'hD0, 0, 0);
    issue_cmd(1'b0, 32'h40, 7);
    rq_addr.push_back(32'h40);
    rq_addr.push_back(32'h41);
    dq_data.push_back(ref_mem[32'h40]);
    dq_last.push_back(0);
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_queues_drained", rq_addr.size() + dq_data.size(), 0);
    chk("midrst_busy_after_release", {31'b0, busy}, 0);
    rd_burst(32'h04, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_wq_empty", wq_addr.size(), 0);
    chk("final_rq_empty", rq_addr.size(), 0);
    chk("final_dq_empty", dq_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Burst sequencer in front of the single-port `sram` block.
- Accepts one command at a time over a valid/ready interface: start address, beat count, direction.
- Walks the address for that many beats and drives `sram` wren/rden/addr/wr_data.
- Streams write data in and read data out, so masters never issue per-word SRAM cycles.

Parameters:
ADDR_WIDTH, sram_pkg::ADDR_WIDTH, SRAM word-address width
DATA_WIDTH, sram_pkg::DATA_WIDTH, SRAM data width
LEN_WIDTH, 4, burst-length field width; bursts of 1..2**LEN_WIDTH beats

Ports:
clk  input  1  clock; all logic on posedge
rstn  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  controller can accept a command (IDLE)
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_WIDTH  first-beat word address
cmd_len  input  LEN_WIDTH  beats minus one
wdata_valid  input  1  write beat available
wdata_ready  output  1  write beat accepted this cycle
wdata  input  DATA_WIDTH  write beat data
rdata_valid  output  1  read beat valid (no backpressure)
rdata  output  DATA_WIDTH  read beat data
rdata_last  output  1  qualifies final read beat
busy  output  1  burst in progress or read drain pending
sram_wren  output  1  to sram wren
sram_rden  output  1  to sram rden
sram_addr  output  ADDR_WIDTH  to sram addr
sram_wr_data  output  DATA_WIDTH  to sram wr_data
sram_rd_data  input  DATA_WIDTH  from sram rd_data

Behaviour:
- Reset (async assert, sync release): state IDLE, addr/count/flags = 0.
- Reset values of outputs:
  - cmd_ready = 1.
  - All other outputs = 0, except rdata, which follows sram_rd_data (also 0 under reset).
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, the command is captured: addr_q = cmd_addr, cnt_q = cmd_len.
  - Next state: WRITE if cmd_write, else READ.
  - No SRAM access in IDLE; sram_wren = sram_rden = 0.
- WRITE:
  - wdata_ready = 1.
  - sram_wren = wdata_valid, sram_addr = addr_q, sram_wr_data = wdata (combinational).
  - Each accepted beat (wdata_valid): addr_q advances (see wrap rule); cnt_q decrements.
  - Beat with cnt_q == 0 → IDLE.
  - wdata_valid low stalls with no SRAM write; there is no timeout.
- READ:
  - sram_rden = 1 every cycle, sram_addr = addr_q; addr_q and cnt_q advance each cycle.
  - When cnt_q == 0 → DRAIN.
  - Read bursts never stall.
- DRAIN: one cycle, no SRAM access → IDLE.
- Read return path:
  - rdata_valid = sram_rden registered (1-cycle latency, matching sram registered read).
  - rdata = sram_rd_data.
  - rdata_last = registered (READ && cnt_q == 0).
  - A burst of N beats yields exactly N consecutive rdata_valid cycles, the first one cycle after the first rden.
- sram_wren and sram_rden are never both 1. sram resolves 11 as write; the controller never relies on that.
- busy = (state != IDLE) || rdata_valid.
- cmd_ready = (state == IDLE). Back-to-back commands are therefore spaced by ≥1 idle cycle.
- Address advance: addr_q + 1 modulo 2**ADDR_WIDTH; top address wraps to 0.
- cmd_len = 0 gives a single-beat burst. cmd_len = all-ones gives 2**LEN_WIDTH beats.
- Reset mid-burst: burst abandoned; no further SRAM access; pending rdata_valid cleared. Partial writes already performed remain in SRAM (SRAM reset clears it if shared rstn).

Optional Feature:
- Macro SRAM_BURST_WRAP_EN.
- Defined:
  - Bursts are wrapping.
  - Only addr_q[LEN_WIDTH-1:0] increments, modulo 2**LEN_WIDTH.
  - Upper address bits stay fixed at cmd_addr[ADDR_WIDTH-1:LEN_WIDTH]. Example: LEN_WIDTH=4, start 0x1E, len 3 → 0x1E, 0x1F, 0x10, 0x11.
- Undefined: linear increment as above (0x1E, 0x1F, 0x20, 0x21).

Test Plan:
- Write burst cmd_addr=0x04, cmd_len=3, data A0..A3, wdata_valid held high → 4 consecutive sram_wren at 0x04..0x07; cmd_ready returns the cycle after the last beat.
- Read burst addr=0x04, len=3 after that write → rdata_valid 4 cycles carrying A0..A3; rdata_last only with A3; busy drops the cycle after A3.
- Write burst len=2 with wdata_valid toggling 1,0,0,1,1 → exactly 3 SRAM writes at consecutive addresses; no wren in stall cycles.
- Top-of-address read: addr=2**ADDR_WIDTH-2, len=3 → addresses max-1, max, 0, 1 (macro off); with SRAM_BURST_WRAP_EN, LEN_WIDTH=4, addr=0x1E → 0x1E, 0x1F, 0x10, 0x11.
- Single beat: cmd_len=0 read of addr 0x09 → one rden, one rdata_valid with rdata_last=1.
- Reset mid-read after 2 of 8 beats → all outputs to reset values immediately; no rdata_valid after release; next command accepted normally.
